// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-channel timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    localparam int NUM_CH_DEF  = 4;
    localparam int CNT_W_DEF   = 16;
    localparam int PRESC_W_DEF = 8;

endpackage

// File: rtl/timer_multich_channel.sv
// One timer channel: FSM, up-counter, period match and sticky flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             chosen_clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             cont,
    input  logic [CNT_W-1:0] period,
    input  logic             clr,
    output logic             timer_out,
    output logic             irq_flag,
    output logic             ch_done,
    output logic [CNT_W-1:0] cnt
);

    ch_state_t state, state_nx;
    logic      match;

    // >= rather than == so a shrunk period still matches on the next tick
    assign match = en && (state == RUN) && tick && (cnt >= period);

    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nx = RUN;
                RUN:     if (match && !cont) state_nx = DONE;
                DONE:    state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timer_out <= 1'b0;
            ch_done   <= 1'b0;
        end else begin
            timer_out <= match;
            if (!en || state == IDLE) begin
                cnt     <= '0;
                ch_done <= 1'b0;
            end else if (state == RUN && tick) begin
                if (match) begin
                    if (cont) cnt <= '0;
                    else      ch_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // a coincident clear loses to a new match
    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst)        irq_flag <= 1'b0;
        else if (match) irq_flag <= 1'b1;
        else if (clr)   irq_flag <= 1'b0;
    end

endmodule

// File: rtl/timer_multich.sv
// Multi-channel timer: input sync, shared prescaler, channels, irq.
module timer_multich
    import timer_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic                    chosen_clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_cont,
    input  logic [NUM_CH*CNT_W-1:0] period_flat,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [NUM_CH-1:0]       irq_clr,
    input  logic [NUM_CH-1:0]       irq_mask,
    output logic [NUM_CH-1:0]       timer_out,
    output logic [NUM_CH-1:0]       irq_flag,
    output logic [NUM_CH-1:0]       ch_done,
    output logic [NUM_CH*CNT_W-1:0] cnt_flat,
    output logic                    irq
);

    logic [NUM_CH-1:0]       en_sync;
    logic [NUM_CH-1:0]       cont_sync;
    logic [NUM_CH*CNT_W-1:0] period_sync;
    logic [PRESC_W-1:0]      presc_sync;
    logic [PRESC_W-1:0]      presc_cnt;
    logic                    any_en;
    logic                    tick;

    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) begin
            en_sync     <= '0;
            cont_sync   <= '0;
            period_sync <= '0;
            presc_sync  <= '0;
        end else begin
            en_sync     <= ch_en;
            cont_sync   <= ch_cont;
            period_sync <= period_flat;
            presc_sync  <= prescale;
        end
    end

    assign any_en = |en_sync;
    assign tick   = any_en && (presc_cnt >= presc_sync);

    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst)               presc_cnt <= '0;
        else if (!any_en)      presc_cnt <= '0;
        else if (tick)         presc_cnt <= '0;
        else                   presc_cnt <= presc_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .chosen_clk(chosen_clk),
            .rst       (rst),
            .tick      (tick),
            .en        (en_sync[i]),
            .cont      (cont_sync[i]),
            .period    (period_sync[i*CNT_W +: CNT_W]),
            .clr       (irq_clr[i]),
            .timer_out (timer_out[i]),
            .irq_flag  (irq_flag[i]),
            .ch_done   (ch_done[i]),
            .cnt       (cnt_flat[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= |(irq_flag & irq_mask);
    end

endmodule

// File: tb/tb_timer_multich.sv
// Directed self-checking bench for timer_multich.
module tb_timer_multich;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int PW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_en = '0;
    logic [NCH-1:0]    ch_cont = '0;
    logic [NCH*CW-1:0] period_flat = '0;
    logic [PW-1:0]     prescale = '0;
    logic [NCH-1:0]    irq_clr = '0;
    logic [NCH-1:0]    irq_mask = '0;
    logic [NCH-1:0]    timer_out;
    logic [NCH-1:0]    irq_flag;
    logic [NCH-1:0]    ch_done;
    logic [NCH*CW-1:0] cnt_flat;
    logic              irq;

    int n_checks = 0;
    int n_err    = 0;

    timer_multich #(
        .NUM_CH (NCH),
        .CNT_W  (CW),
        .PRESC_W(PW)
    ) dut (
        .chosen_clk (clk),
        .rst        (rst),
        .ch_en      (ch_en),
        .ch_cont    (ch_cont),
        .period_flat(period_flat),
        .prescale   (prescale),
        .irq_clr    (irq_clr),
        .irq_mask   (irq_mask),
        .timer_out  (timer_out),
        .irq_flag   (irq_flag),
        .ch_done    (ch_done),
        .cnt_flat   (cnt_flat),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int i);
        return cnt_flat[i*CW +: CW];
    endfunction

    task automatic set_period(input int i, input logic [CW-1:0] p);
        period_flat[i*CW +: CW] = p;
    endtask

    task automatic do_reset();
        ch_en = '0;
        ch_cont = '0;
        period_flat = '0;
        prescale = '0;
        irq_clr = '0;
        irq_mask = '0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt[10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};
        int exp_to[10]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        int pulses;
        logic [31:0] vec;

        #1;
        check("rst_timer_out", timer_out, 0);
        check("rst_flag", irq_flag, 0);
        check("rst_cnt", cnt_flat[31:0], 0);
        check("rst_irq", irq, 0);
        do_reset();

        // continuous, period 3
        set_period(0, 3);
        ch_cont = 4'b0001;
        ch_en = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check($sformatf("cont_cnt_%0d", k + 1), cnt_of(0), exp_cnt[k]);
            check($sformatf("cont_to_%0d", k + 1), timer_out[0], exp_to[k]);
            if (k == 4) check("cont_flag_pre", irq_flag[0], 0);
        end
        check("cont_flag", irq_flag[0], 1);

        // one-shot, period 5
        do_reset();
        set_period(1, 5);
        ch_en = 4'b0010;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 8) check("os_to_at8", timer_out[1], 1);
            pulses += int'(timer_out[1]);
        end
        check("os_pulses", pulses, 1);
        check("os_done", ch_done[1], 1);
        check("os_cnt", cnt_of(1), 5);
        ch_en = 4'b0000;
        step(2);
        check("os_dis_cnt", cnt_of(1), 0);
        check("os_dis_done", ch_done[1], 0);
        check("os_dis_flag", irq_flag[1], 1);
        ch_en = 4'b0010;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            pulses += int'(timer_out[1]);
        end
        check("os_re_pulses", pulses, 1);
        check("os_re_done", ch_done[1], 1);

        // prescaler 2, then 0 mid-run
        do_reset();
        prescale = 2;
        set_period(0, 1);
        ch_cont = 4'b0001;
        ch_en = 4'b0001;
        vec = '0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            vec[k] = timer_out[0];
            if (k == 13) prescale = 0;
        end
        check("presc_pulses", vec, 32'h0015_2080);

        // flags and mask
        do_reset();
        irq_mask = 4'b0010;
        set_period(0, 1);
        set_period(1, 3);
        ch_cont = 4'b0011;
        ch_en = 4'b0011;
        step(5);
        check("flag0_set", irq_flag[0], 1);
        check("irq_masked", irq, 0);
        step(1);
        check("flag1_set", irq_flag[1], 1);
        check("irq_lag", irq, 0);
        step(1);
        check("irq_on", irq, 1);
        step(2);
        irq_clr = 4'b0010;
        step(1);
        irq_clr = 4'b0000;
        check("clr_match_to", timer_out[1], 1);
        check("set_wins", irq_flag[1], 1);
        step(1);
        irq_clr = 4'b0010;
        step(1);
        irq_clr = 4'b0000;
        check("clr_flag", irq_flag[1], 0);
        check("clr_irq_lag", irq, 1);
        step(1);
        check("clr_irq", irq, 0);
        check("clr_other", irq_flag[0], 1);

        // period 0 and period shrink
        do_reset();
        set_period(3, 10);
        ch_cont = 4'b1100;
        ch_en = 4'b1100;
        step(2);
        pulses = 0;
        for (int k = 3; k <= 6; k++) begin
            step(1);
            pulses += int'(timer_out[2]);
        end
        check("p0_every_tick", pulses, 4);
        step(3);
        check("shrink_cnt7", cnt_of(3), 7);
        set_period(3, 2);
        step(1);
        check("shrink_cnt8", cnt_of(3), 8);
        check("shrink_to_pre", timer_out[3], 0);
        step(1);
        check("shrink_to", timer_out[3], 1);
        check("shrink_cnt0", cnt_of(3), 0);

        // full-range period
        do_reset();
        set_period(0, 16'hFFFF);
        ch_cont = 4'b0001;
        ch_en = 4'b0001;
        pulses = 0;
        for (int k = 1; k <= 65537; k++) begin
            step(1);
            pulses += int'(timer_out[0]);
        end
        check("max_no_pulse", pulses, 0);
        check("max_cnt", cnt_of(0), 16'hFFFF);
        step(1);
        check("max_to", timer_out[0], 1);
        check("max_wrap", cnt_of(0), 0);

        // async reset mid-run
        do_reset();
        irq_mask = 4'b0001;
        set_period(0, 3);
        ch_cont = 4'b0001;
        ch_en = 4'b0001;
        step(8);
        check("mr_pre_irq", irq, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_to", timer_out, 0);
        check("mr_flag", irq_flag, 0);
        check("mr_cnt", cnt_of(0), 0);
        check("mr_irq", irq, 0);
        #2;
        rst = 1'b0;
        step(2);
        check("mr_cnt2", cnt_of(0), 0);
        step(1);
        check("mr_cnt3", cnt_of(0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/timer_multich.md
Name: timer_multich

Overview:
- Parametrised multi-channel successor to the single-channel PWM/timer-mode block.
- Each channel has its own internal up-counter, period, enable and mode:
  - continuous (auto-reload) or one-shot.
- Per-channel sticky interrupt flags are cleared by write-1-to-clear (W1C) pulses from the Wishbone register side.
- Unmasked flags are ORed into one interrupt line.
- A shared prescaler divides the chosen clock for all channels.
- Sits between the register file (ctrl/period registers) and the o_pwm/irq outputs.

Parameters:
- NUM_CH, 4: number of independent timer channels (1..8).
- CNT_W, 16: counter and period width in bits.
- PRESC_W, 8: prescaler register width.

Ports:
- chosen_clk  in  1  active-high clock; the already-selected i_wb_clk/i_ext_clk.
- rst  in  1  asynchronous, active-high reset (i_wb_rst).
- ch_en  in  NUM_CH  per-channel enable: ~ctrl[1] & ctrl[2] per channel.
- ch_cont  in  NUM_CH  1 = continuous/auto-reload, 0 = one-shot.
- period_flat  in  NUM_CH*CNT_W  per-channel period; channel i uses bits [i*CNT_W +: CNT_W].
- prescale  in  PRESC_W  tick every prescale+1 clocks; 0 = every clock.
- irq_clr  in  NUM_CH  W1C pulse; clears irq_flag[i].
- irq_mask  in  NUM_CH  1 = channel contributes to irq.
- timer_out  out  NUM_CH  one-clock pulse on each period match.
- irq_flag  out  NUM_CH  sticky match flags (to ctrl[5] per channel).
- ch_done  out  NUM_CH  high while a one-shot channel has expired.
- cnt_flat  out  NUM_CH*CNT_W  current counter values (read-back).
- irq  out  1  |(irq_flag & irq_mask), registered.

Behaviour:
- Reset (async, rst=1): every register and output is 0; all channels are IDLE; the prescaler count is 0.
- Sync stage:
  - ch_en, ch_cont, period_flat and prescale are registered once on chosen_clk (en_sync, cont_sync, period_sync, presc_sync).
  - All logic below uses the synced copies, giving 1 clock of input latency.
- Prescaler:
  - presc_cnt counts 0..presc_sync; tick=1 in the cycle presc_cnt==presc_sync, then presc_cnt wraps to 0.
  - presc_cnt is held at 0 (tick=0) while no en_sync bit is set.
  - If prescale is lowered below presc_cnt, the >= compare produces a tick and a wrap on the next cycle.
- Per-channel FSM, states IDLE, RUN, DONE:
  - IDLE: cnt=0. When en_sync=1, go to RUN.
  - RUN, on tick:
    - If cnt >= period_sync (match): timer_out pulses 1 for that clock and irq_flag is set.
      - cont_sync=1: cnt<=0, stay in RUN.
      - cont_sync=0: go to DONE, cnt holds, ch_done<=1.
    - Else cnt<=cnt+1.
  - RUN, no tick: cnt holds.
  - DONE: cnt frozen; timer_out=0. Leave only via en_sync=0, which goes to IDLE.
  - Any state with en_sync=0: go to IDLE next clock, cnt<=0, timer_out<=0, ch_done<=0. irq_flag is retained.
- Period semantics:
  - Match-to-match distance is (period+1) ticks.
  - period=0 matches on every tick, so timer_out is high every tick.
  - Reducing period below the current cnt gives a match on the next tick (>= compare; no wrap through 2^CNT_W).
  - cnt never exceeds 2^CNT_W-1; no overflow is possible.
- Toggling cont_sync mid-run takes effect at the next match.
- irq_flag[i]:
  - Set on match; cleared on an irq_clr[i] pulse.
  - If set and clear occur in the same clock, set wins and the flag stays 1.
  - Flags are not cleared by disabling the channel.
- irq: registered OR of irq_flag & irq_mask, so it lags irq_flag by 1 clock.
- Latency: ch_en rising sampled at edge k → en_sync at k → RUN at k+1. With prescale=0, the first increment is at edge k+2.
- Channels are fully independent apart from the shared prescaler.

Decomposition:
- Shared package timer_pkg holds:
  - FSM state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default parameter constants.
- One natural sub-module, timer_channel: holds the FSM, counter, match and flag logic for a single channel.
- timer_multich contains:
  - the sync stage;
  - the prescaler;
  - a generate loop of NUM_CH timer_channel instances;
  - the irq OR-reduction.

Test Plan:
- Continuous: prescale=0, ch0 period=3, cont=1, en=1 → timer_out[0] pulses every 4 clocks; cnt sequence 0,1,2,3,0; irq_flag[0] set at first match and stays set.
- One-shot: ch1 period=5, cont=0 → exactly one timer_out[1] pulse; ch_done[1]=1, cnt frozen at 5. Then en=0 → IDLE, cnt=0, ch_done=0. Re-enable → one new pulse.
- Prescaler: prescale=2, period=1, cont=1 → timer_out pulse every 6 clocks. Then prescale=0 mid-run → next pulse within 2 clocks, then every 2 clocks.
- Flag/mask: irq_mask=4'b0010 with ch0 and ch1 matching → irq=1 only once flag[1] sets. irq_clr[1] coincident with a ch1 match → flag stays 1. A lone irq_clr[1] → flag 0, irq 0 one clock later.
- Boundaries: period=0 → timer_out high every tick. Period changed from 10 to 2 while cnt=7 → match on next tick. CNT_W=16, period=16'hFFFF → match after 65536 ticks with no wrap glitch.
- Reset mid-run: rst asserted asynchronously between edges while channels are counting → all outputs 0 immediately. After release with en held high, counting restarts from 0 following the 2-clock latency.
